// File: rtl/rf_dump_reader.sv
// Register-file dump engine: streams x[FIRST_REG..LAST_REG] over valid/ready.
// Define RF_DUMP_CKSUM_EN to append an XOR checksum word after the last register.
module rf_dump_reader #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rf_ra,
    input  logic [31:0] rf_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_idx,
    output logic        out_last,
    output logic        out_cksum
);

    localparam logic [4:0] FIRST = 5'(FIRST_REG);
    localparam logic [4:0] LAST  = 5'(LAST_REG);

`ifdef RF_DUMP_CKSUM_EN
    typedef enum logic [1:0] {IDLE, READ, SEND, CKSUM} state_t;
`else
    typedef enum logic [1:0] {IDLE, READ, SEND} state_t;
`endif

    state_t      state, state_n;
    logic [4:0]  ptr, ptr_n;
    logic [31:0] acc, acc_n;
    logic        valid_n, last_n, done_n;
    logic [31:0] data_n;
    logic [4:0]  idx_n;
`ifdef RF_DUMP_CKSUM_EN
    logic        cks_n;
`endif

    assign rf_ra = ptr;
    assign busy  = (state != IDLE);

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        acc_n   = acc;
        valid_n = out_valid;
        data_n  = out_data;
        idx_n   = out_idx;
        last_n  = out_last;
        done_n  = 1'b0;
`ifdef RF_DUMP_CKSUM_EN
        cks_n   = out_cksum;
`endif
        unique case (state)
            IDLE: begin
                if (start) begin
                    ptr_n   = FIRST;
                    acc_n   = '0;
                    state_n = READ;
                end
            end
            READ: begin
                data_n  = rf_rd;
                idx_n   = ptr;
                acc_n   = acc ^ rf_rd;
                valid_n = 1'b1;
`ifdef RF_DUMP_CKSUM_EN
                last_n  = 1'b0;
`else
                last_n  = (ptr == LAST);
`endif
                state_n = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    if (ptr != LAST) begin
                        valid_n = 1'b0;
                        ptr_n   = ptr + 5'd1;
                        state_n = READ;
                    end else begin
`ifdef RF_DUMP_CKSUM_EN
                        // acc already folds in the final register word
                        data_n  = acc;
                        cks_n   = 1'b1;
                        last_n  = 1'b1;
                        idx_n   = '0;
                        state_n = CKSUM;
`else
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = IDLE;
`endif
                    end
                end
            end
`ifdef RF_DUMP_CKSUM_EN
            CKSUM: begin
                if (out_ready) begin
                    valid_n = 1'b0;
                    cks_n   = 1'b0;
                    last_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            ptr       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            acc       <= acc_n;
            out_valid <= valid_n;
            out_data  <= data_n;
            out_idx   <= idx_n;
            out_last  <= last_n;
            done      <= done_n;
        end
    end

`ifdef RF_DUMP_CKSUM_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) out_cksum <= 1'b0;
        else       out_cksum <= cks_n;
    end
`else
    assign out_cksum = 1'b0;
`endif

endmodule

// File: tb/tb_rf_dump_reader.sv
// Randomized bench for rf_dump_reader against a queue-based dump model.
// Honours RF_DUMP_CKSUM_EN the same way the design does.
module tb_rf_dump_reader;

`ifdef RF_DUMP_CKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nrst;
    logic        start, out_ready;
    logic        busy, done, out_valid, out_last, out_cksum;
    logic [4:0]  rf_ra, out_idx;
    logic [31:0] rf_rd, out_data;

    logic        s_start, s_ready;
    logic        s_busy, s_done, s_valid, s_last, s_cksum;
    logic [4:0]  s_ra, s_idx;
    logic [31:0] s_rd, s_data;

    logic [31:0] rf [32];

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
        logic        ck;
    } word_t;

    always #5 clk = ~clk;

    assign rf_rd = rf[rf_ra];
    assign s_rd  = rf[s_ra];

    rf_dump_reader u_dut (
        .clk(clk), .nrst(nrst), .start(start), .busy(busy), .done(done),
        .rf_ra(rf_ra), .rf_rd(rf_rd), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .out_last(out_last), .out_cksum(out_cksum)
    );

    rf_dump_reader #(.FIRST_REG(5), .LAST_REG(5)) u_one (
        .clk(clk), .nrst(nrst), .start(s_start), .busy(s_busy), .done(s_done),
        .rf_ra(s_ra), .rf_rd(s_rd), .out_valid(s_valid),
        .out_ready(s_ready), .out_data(s_data), .out_idx(s_idx),
        .out_last(s_last), .out_cksum(s_cksum)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_flags"}, {27'd0, busy, done, out_valid, out_last, out_cksum}, 32'd0);
        chk({tag, "_ra"}, {27'd0, rf_ra}, 32'd0);
        chk({tag, "_data"}, out_data, 32'd0);
        chk({tag, "_idx"}, {27'd0, out_idx}, 32'd0);
    endtask

    task automatic preload();
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : 32'h1000_0000 + i;
    endtask

    task automatic randomize_rf();
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : $urandom;
    endtask

    // prob: percent chance out_ready is high; rst_at: cycle to pulse nrst (0 = never)
    task automatic run_dump(input int prob, input bit repulse, input int rst_at);
        word_t       exp_q[$];
        word_t       w;
        logic [31:0] x, pd;
        logic [4:0]  pi;
        bit          fin, pstall;
        int          stalls, first_v, exp_done;
        x = '0;
        for (int i = 0; i < 32; i++) begin
            w.idx  = 5'(i);
            w.data = rf[i];
            w.last = (i == 31) && !CK;
            w.ck   = 1'b0;
            x      = x ^ rf[i];
            exp_q.push_back(w);
        end
        if (CK) begin
            w.idx = 5'd0; w.data = x; w.last = 1'b1; w.ck = 1'b1;
            exp_q.push_back(w);
        end
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        stalls = 0; first_v = 0; fin = 0; pstall = 0; pd = '0; pi = '0;
        for (int c = 1; c <= 400 && !fin; c++) begin
            @(negedge clk);
            start = repulse && (c == 3 || c == 40);
            if (rst_at == c) begin
                nrst = 1'b0;
                #1;
                chk_zero("midrst");
                @(negedge clk);
                chk("midrst_done", {31'd0, done}, 32'd0);
                start = 1'b0;
                nrst = 1'b1;
                @(negedge clk);
                chk_zero("post_rst");
                return;
            end
            out_ready = ($urandom_range(0, 99) < prob);
            if (done) begin
                exp_done = 65 + stalls + (CK ? 1 : 0);
                chk("done_cycle", c, exp_done);
                chk("valid_at_done", {31'd0, out_valid}, 32'd0);
                chk("busy_at_done", {31'd0, busy}, 32'd0);
                fin = 1;
            end else begin
                chk("busy", {31'd0, busy}, 32'd1);
                if (out_valid) begin
                    if (first_v == 0) begin
                        first_v = c;
                        chk("first_valid", c, 2);
                    end
                    if (pstall) begin
                        chk("stall_data", out_data, pd);
                        chk("stall_idx", {27'd0, out_idx}, {27'd0, pi});
                    end
                    if (out_ready) begin
                        chk("word_avail", {31'd0, exp_q.size() > 0}, 32'd1);
                        if (exp_q.size() > 0) begin
                            w = exp_q.pop_front();
                            chk("idx", {27'd0, out_idx}, {27'd0, w.idx});
                            chk("data", out_data, w.data);
                            chk("last", {31'd0, out_last}, {31'd0, w.last});
                            chk("cksum", {31'd0, out_cksum}, {31'd0, w.ck});
                        end
                    end else begin
                        stalls++;
                    end
                    pstall = !out_ready;
                    pd = out_data;
                    pi = out_idx;
                end else begin
                    pstall = 0;
                end
            end
        end
        chk("timeout", {31'd0, fin}, 32'd1);
        chk("words_left", exp_q.size(), 0);
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_after", {29'd0, busy, done, out_valid}, 32'd0);
        end
    endtask

    task automatic run_single();
        int c;
        rf[5] = 32'hDEAD_BEEF;
        @(negedge clk);
        s_start = 1'b1;
        s_ready = 1'b1;
        @(posedge clk);
        c = 0;
        do begin
            @(negedge clk);
            s_start = 1'b0;
            c++;
        end while (!s_valid && c < 10);
        chk("one_first", c, 2);
        chk("one_idx", {27'd0, s_idx}, 32'd5);
        chk("one_data", s_data, 32'hDEAD_BEEF);
        chk("one_last", {31'd0, s_last}, {31'd0, !CK});
        chk("one_ck", {31'd0, s_cksum}, 32'd0);
`ifdef RF_DUMP_CKSUM_EN
        @(negedge clk);
        chk("one_cks_valid", {31'd0, s_valid}, 32'd1);
        chk("one_cks_data", s_data, 32'hDEAD_BEEF);
        chk("one_cks_flags", {30'd0, s_cksum, s_last}, 32'd3);
        chk("one_cks_idx", {27'd0, s_idx}, 32'd0);
`endif
        @(negedge clk);
        chk("one_done", {30'd0, s_done, s_valid}, 32'd2);
        @(negedge clk);
        chk("one_done_pulse", {30'd0, s_done, s_busy}, 32'd0);
    endtask

    initial begin
        nrst = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        s_start = 1'b0;
        s_ready = 1'b0;
        repeat (4) begin
            start = 1'($urandom);
            out_ready = 1'($urandom);
            randomize_rf();
            @(negedge clk);
            chk_zero("reset");
        end
        start = 1'b0;
        preload();
        @(negedge clk);
        nrst = 1'b1;

        run_dump(100, 0, 0);
        randomize_rf();
        run_dump(50, 0, 0);
        randomize_rf();
        run_dump(50, 0, 0);
        preload();
        run_dump(100, 1, 0);
        run_dump(100, 0, 20);
        run_dump(100, 0, 0);
        run_single();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
